matmul_row_scheduler: RTL

- Sequences the matrix-multiply controller row by row over a programmed range [first_row..last_row] of the 10x10 result matrix.
- Drives the controller's start/which_row inputs and watches its done output.
- Handles the controller's level-held done flag, which stays high until the next row begins; waits for done low before waiting for done high.
- Sits between the host/top-level sequencer and the matrix controller. Provides busy/finished/error status, per-row timeout and abort.

---
 rtl/matmul_pkg.sv | 16 +
 rtl/matmul_row_scheduler_if.sv | 27 ++
 rtl/matmul_row_scheduler_sched_timer.sv | 26 ++
 rtl/matmul_row_scheduler.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared sizes and state encoding for the matrix row scheduler
package matmul_pkg;

  localparam int ROWS  = 10;
  localparam int ROW_W = 4;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LAUNCH    = 3'd1;
  localparam logic [2:0] S_WAIT_ACK  = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RELEASE   = 3'd4;
  localparam logic [2:0] S_FINISH    = 3'd5;
  localparam logic [2:0] S_FAULT     = 3'd6;
  localparam logic [2:0] S_DRAIN     = 3'd7;

endpackage

// File: rtl/matmul_row_scheduler_if.sv
// rtl/matmul_row_scheduler_if.sv - host and controller signals of the row scheduler
interface matmul_row_scheduler_if;

  logic                                go;
  logic [matmul_pkg::ROW_W-1:0]        first_row;
  logic [matmul_pkg::ROW_W-1:0]        last_row;
  logic                                abort;
  logic                                ctl_done;
  logic                                ctl_start;
  logic [matmul_pkg::ROW_W-1:0]        ctl_row;
  logic                                busy;
  logic                                finished;
  logic                                error;
  logic                                aborted;
  logic [matmul_pkg::ROW_W:0]          rows_done;

  modport slave (
    input  go, first_row, last_row, abort, ctl_done,
    output ctl_start, ctl_row, busy, finished, error, aborted, rows_done
  );

  modport master (
    output go, first_row, last_row, abort, ctl_done,
    input  ctl_start, ctl_row, busy, finished, error, aborted, rows_done
  );

endinterface

// File: rtl/matmul_row_scheduler_sched_timer.sv
// rtl/matmul_row_scheduler_sched_timer.sv - clearable up-counter with limit compare
module sched_timer #(
  parameter int TO_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic [TO_W-1:0] i_limit,
  output logic            o_hit
);

  logic [TO_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (r_count != i_limit) begin
      r_count <= r_count + TO_W'(1);
    end
  end

  assign o_hit = (r_count == i_limit);

endmodule

// File: rtl/matmul_row_scheduler.sv
// rtl/matmul_row_scheduler.sv - steps the matrix controller through a range of result rows
module matmul_row_scheduler
  import matmul_pkg::*;
#(
  parameter int GAP     = 2,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  matmul_row_scheduler_if.slave  bus
);

  localparam logic [ROW_W:0]  ROWS_LIM = (ROW_W+1)'(ROWS);
  localparam logic [TO_W-1:0] TO_LIM   = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] GAP_LIM  = TO_W'(GAP - 1);

  logic [2:0]       r_state;
  logic [ROW_W-1:0] r_cur;
  logic [ROW_W-1:0] r_last;
  logic             r_ctl_start;
  logic [ROW_W-1:0] r_ctl_row;
  logic             r_busy;
  logic             r_finished;
  logic             r_error;
  logic             r_aborted;
  logic [ROW_W:0]   r_rows_done;

  logic [2:0]       w_next;
  logic             w_bad_range;
  logic             w_active;
  logic             w_abort;
  logic             w_counting;
  logic             w_tmr_clr;
  logic             w_tmr_hit;
  logic [TO_W-1:0]  w_tmr_limit;

  assign w_bad_range = (bus.first_row > bus.last_row) || ({1'b0, bus.last_row} >= ROWS_LIM);
  assign w_active    = (r_state == S_LAUNCH) || (r_state == S_WAIT_ACK) ||
                       (r_state == S_WAIT_DONE) || (r_state == S_RELEASE);
  assign w_abort     = bus.abort && w_active;
  assign w_counting  = (r_state == S_WAIT_ACK) || (r_state == S_WAIT_DONE) ||
                       (r_state == S_RELEASE) || (r_state == S_DRAIN);
  // One counter serves both the per-phase timeout and the inter-row gap.
  assign w_tmr_clr   = !w_counting || (w_next != r_state);
  assign w_tmr_limit = (r_state == S_RELEASE) ? GAP_LIM : TO_LIM;

  sched_timer #(.TO_W(TO_W)) u_timer (
    .clk     (clk),
    .rst_n   (reset),
    .i_clr   (w_tmr_clr),
    .i_limit (w_tmr_limit),
    .o_hit   (w_tmr_hit)
  );

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_DRAIN;
    end else begin
      case (r_state)
        S_IDLE:      if (bus.go) w_next = w_bad_range ? S_FAULT : S_LAUNCH;
        S_LAUNCH:    w_next = S_WAIT_ACK;
        S_WAIT_ACK:  if (!bus.ctl_done) w_next = S_WAIT_DONE;
                     else if (w_tmr_hit) w_next = S_FAULT;
        S_WAIT_DONE: if (bus.ctl_done) w_next = S_RELEASE;
                     else if (w_tmr_hit) w_next = S_FAULT;
        S_RELEASE:   if (w_tmr_hit) w_next = (r_cur == r_last) ? S_FINISH : S_LAUNCH;
        S_FINISH:    w_next = S_IDLE;
        S_FAULT:     w_next = S_IDLE;
        S_DRAIN:     if (bus.ctl_done) w_next = S_FINISH;
                     else if (w_tmr_hit) w_next = S_FAULT;
        default:     w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cur       <= '0;
      r_last      <= '0;
      r_ctl_start <= 1'b0;
      r_ctl_row   <= '0;
      r_busy      <= 1'b0;
      r_finished  <= 1'b0;
      r_error     <= 1'b0;
      r_aborted   <= 1'b0;
      r_rows_done <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      if (w_abort) begin
        r_ctl_start <= 1'b0;
        r_aborted   <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.go) begin
              r_cur       <= bus.first_row;
              r_last      <= bus.last_row;
              r_finished  <= 1'b0;
              r_error     <= 1'b0;
              r_aborted   <= 1'b0;
              r_rows_done <= '0;
            end
          end
          S_LAUNCH: begin
            r_ctl_row   <= r_cur;
            r_ctl_start <= 1'b1;
          end
          S_WAIT_DONE: begin
            if (bus.ctl_done) begin
              r_ctl_start <= 1'b0;
              r_rows_done <= r_rows_done + (ROW_W+1)'(1);
            end
          end
          S_RELEASE: begin
            if (w_tmr_hit && (r_cur != r_last)) r_cur <= r_cur + ROW_W'(1);
          end
          S_FINISH: r_finished <= 1'b1;
          S_FAULT: begin
            r_ctl_start <= 1'b0;
            r_error     <= 1'b1;
            r_finished  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ctl_start = r_ctl_start;
  assign bus.ctl_row   = r_ctl_row;
  assign bus.busy      = r_busy;
  assign bus.finished  = r_finished;
  assign bus.error     = r_error;
  assign bus.aborted   = r_aborted;
  assign bus.rows_done = r_rows_done;

endmodule
